// File: rtl/eeprom_arb.sv
// Purpose : round-robin arbiter/sequencer sharing one serial EEPROM byte engine between two ports.
// Latency : req to ISSUE 1 cycle; done 1 cycle after eng_ack (read) or 1+TWR_CYCLES cycles (write).
// Backpr. : requesters hold req until their done; the loser waits in place, nothing is queued.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   reqN_i, wr_nrdN_i        per-port request and direction (1 = write)
//   addrN_i, wdataN_i        per-port byte address and write byte
//   gntN_o, doneN_o          ownership (ISSUE..DONE) and one-cycle completion pulse
//   rdata_o, err_o, busy_o   read byte (valid with done), timeout flag, non-idle status
//   eng_*                    engine strobes, held address/data, read data and ack
// Optional feature: define EEPROM_ARB_TIMEOUT_EN to bound WAIT_ACK at TIMEOUT_CYCLES.
module eeprom_arb #(
    parameter logic [15:0] TWR_CYCLES     = 16'd1000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        wr_nrd0_i,
    input  logic        wr_nrd1_i,
    input  logic [10:0] addr0_i,
    input  logic [10:0] addr1_i,
    input  logic [7:0]  wdata0_i,
    input  logic [7:0]  wdata1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        done0_o,
    output logic        done1_o,
    output logic [7:0]  rdata_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        eng_wr_o,
    output logic        eng_rd_o,
    output logic [10:0] eng_addr_o,
    output logic [7:0]  eng_wdata_o,
    input  logic [7:0]  eng_rdata_i,
    input  logic        eng_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        last_q;      // most recently served port
    logic        owner_q;     // port owning the current transaction
    logic        wr_nrd_q;
    logic [15:0] twr_cnt_q;
    logic        gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic        eng_wr_q, eng_rd_q;
    logic [10:0] eng_addr_q;
    logic [7:0]  eng_wdata_q;
    logic [7:0]  rdata_q;

    logic        win_d;       // arbitration winner, 1 = port 1
    logic        timeout_d;
    logic        go_done_d;

`ifdef EEPROM_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        err_q;

    assign timeout_d = (state_q == S_WAIT_ACK) && !eng_ack_i
                       && (to_cnt_q == TIMEOUT_CYCLES - 16'd1);
    assign err_o     = err_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_d             = 1'b0;
    assign err_o                 = 1'b0;
`endif

    // On a tie the port that was not served last wins.
    always_comb begin
        win_d = 1'b0;
        if (req0_i && req1_i) begin
            win_d = ~last_q;
        end else begin
            win_d = req1_i;
        end
    end

    // All paths into DONE; a write with zero recovery skips RECOVER entirely.
    always_comb begin
        go_done_d = 1'b0;
        if ((state_q == S_WAIT_ACK) && eng_ack_i && (!wr_nrd_q || (TWR_CYCLES == 16'd0))) begin
            go_done_d = 1'b1;
        end
        if ((state_q == S_RECOVER) && (twr_cnt_q <= 16'd1)) begin
            go_done_d = 1'b1;
        end
        if (timeout_d) begin
            go_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            wr_nrd_q    <= 1'b0;
            twr_cnt_q   <= 16'd0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            eng_wr_q    <= 1'b0;
            eng_rd_q    <= 1'b0;
            eng_addr_q  <= 11'd0;
            eng_wdata_q <= 8'd0;
            rdata_q     <= 8'd0;
`ifdef EEPROM_ARB_TIMEOUT_EN
            to_cnt_q    <= 16'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            // Strobes and done are single-cycle pulses.
            eng_wr_q <= 1'b0;
            eng_rd_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;

            if (go_done_d) begin
                state_q   <= S_DONE;
                done0_q   <= ~owner_q;
                done1_q   <= owner_q;
                last_q    <= owner_q;
                twr_cnt_q <= 16'd0;
`ifdef EEPROM_ARB_TIMEOUT_EN
                to_cnt_q  <= 16'd0;
                if (timeout_d) begin
                    rdata_q <= 8'h00;
                    err_q   <= 1'b1;
                end else
`endif
                if (!wr_nrd_q) begin
                    rdata_q <= eng_rdata_i;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req0_i || req1_i) begin
                            owner_q     <= win_d;
                            wr_nrd_q    <= win_d ? wr_nrd1_i : wr_nrd0_i;
                            eng_addr_q  <= win_d ? addr1_i : addr0_i;
                            eng_wdata_q <= win_d ? wdata1_i : wdata0_i;
                            eng_wr_q    <= win_d ? wr_nrd1_i : wr_nrd0_i;
                            eng_rd_q    <= win_d ? ~wr_nrd1_i : ~wr_nrd0_i;
                            gnt0_q      <= ~win_d;
                            gnt1_q      <= win_d;
                            busy_q      <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT_ACK;
`ifdef EEPROM_ARB_TIMEOUT_EN
                        to_cnt_q <= 16'd0;
`endif
                    end
                    S_WAIT_ACK: begin
                        // Only a write with non-zero recovery reaches here on ack.
                        if (eng_ack_i) begin
                            twr_cnt_q <= TWR_CYCLES;
                            state_q   <= S_RECOVER;
                        end
`ifdef EEPROM_ARB_TIMEOUT_EN
                        else begin
                            to_cnt_q <= to_cnt_q + 16'd1;
                        end
`endif
                    end
                    S_RECOVER: begin
                        twr_cnt_q <= twr_cnt_q - 16'd1;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        busy_q  <= 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign eng_wr_o    = eng_wr_q;
    assign eng_rd_o    = eng_rd_q;
    assign eng_addr_o  = eng_addr_q;
    assign eng_wdata_o = eng_wdata_q;

endmodule

// File: tb/tb_eeprom_arb.sv
// Purpose : directed self-checking bench for eeprom_arb (TWR_CYCLES = 4, TIMEOUT_CYCLES = 8).
// Latency : inputs driven and outputs sampled on the falling edge, half a cycle from the DUT edge.
// Backpr. : a small engine model acks strobes after a programmable latency, or never.
module tb_eeprom_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req0_i = 1'b0, req1_i = 1'b0;
    logic        wr_nrd0_i = 1'b0, wr_nrd1_i = 1'b0;
    logic [10:0] addr0_i = '0, addr1_i = '0;
    logic [7:0]  wdata0_i = '0, wdata1_i = '0;
    logic        gnt0_o, gnt1_o, done0_o, done1_o, err_o, busy_o, eng_wr_o, eng_rd_o;
    logic [7:0]  rdata_o, eng_wdata_o;
    logic [10:0] eng_addr_o;
    logic [7:0]  eng_rdata_i = '0;
    logic        eng_ack_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n;
    int base;

    // Engine model configuration
    bit       eng_auto = 1'b1;
    int       eng_lat  = 1;
    logic [7:0] eng_data = 8'h00;

    eeprom_arb #(.TWR_CYCLES(16'd4), .TIMEOUT_CYCLES(16'd8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_i(req0_i), .req1_i(req1_i),
        .wr_nrd0_i(wr_nrd0_i), .wr_nrd1_i(wr_nrd1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i),
        .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
        .done0_o(done0_o), .done1_o(done1_o),
        .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
        .eng_wr_o(eng_wr_o), .eng_rd_o(eng_rd_o),
        .eng_addr_o(eng_addr_o), .eng_wdata_o(eng_wdata_o),
        .eng_rdata_i(eng_rdata_i), .eng_ack_i(eng_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Engine: ack eng_lat cycles after seeing a strobe.
    initial begin
        forever begin
            @(negedge clk_i);
            if (eng_auto && (eng_rd_o || eng_wr_o)) begin
                repeat (eng_lat) @(negedge clk_i);
                eng_ack_i   = 1'b1;
                eng_rdata_i = eng_data;
                @(negedge clk_i);
                eng_ack_i   = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (eng_rd_o || eng_wr_o) n_strobe++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Advance until the port's done is seen or the budget runs out; cnt = cycles advanced.
    task automatic wait_done(input int port, input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_i);
            cnt++;
        end while (!((port == 0) ? done0_o : done1_o) && cnt < max);
    endtask

    task automatic wait_any(input bit want_gnt, input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_i);
            cnt++;
        end while (!(want_gnt ? (gnt0_o || gnt1_o) : (done0_o || done1_o)) && cnt < max);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {gnt0_o, gnt1_o, done0_o, done1_o, err_o, busy_o,
                                  eng_wr_o, eng_rd_o}, 32'h0);
        check_eq({tag, "_rdata"}, rdata_o, 32'h0);
        check_eq({tag, "_addr"}, eng_addr_o, 32'h0);
        check_eq({tag, "_wdata"}, eng_wdata_o, 32'h0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check_all_zero("reset");
        rst_ni = 1'b1;

        // Single read, port 0, engine acks 5 cycles after the strobe
        eng_lat = 5; eng_data = 8'hA5;
        base = n_strobe;
        req0_i = 1'b1; wr_nrd0_i = 1'b0; addr0_i = 11'h155;
        tick();
        check_eq("rd_issue_strobe", {eng_rd_o, eng_wr_o}, 32'h2);
        check_eq("rd_issue_gnt", {gnt0_o, gnt1_o, busy_o}, 32'h5);
        check_eq("rd_issue_addr", eng_addr_o, 32'h155);
        wait_done(0, 20, n);
        check_eq("rd_done_lat", n, 6);
        check_eq("rd_done0", done0_o, 1);
        check_eq("rd_done1", done1_o, 0);
        check_eq("rd_rdata", rdata_o, 32'hA5);
        check_eq("rd_addr_held", eng_addr_o, 32'h155);
        req0_i = 1'b0;
        tick();
        check_eq("rd_after", {done0_o, gnt0_o, busy_o}, 32'h0);
        check_eq("rd_strobes", n_strobe - base, 1);

        // Write recovery on port 1; port 0 requests during RECOVER
        eng_lat = 2; eng_data = 8'hEE;
        req1_i = 1'b1; wr_nrd1_i = 1'b1; addr1_i = 11'h7FF; wdata1_i = 8'h3C;
        tick();
        check_eq("wr_issue_strobe", {eng_rd_o, eng_wr_o}, 32'h1);
        check_eq("wr_issue_data", {eng_addr_o, eng_wdata_o}, {11'h7FF, 8'h3C});
        check_eq("wr_issue_gnt", {gnt0_o, gnt1_o}, 32'h1);
        repeat (4) tick();
        check_eq("wr_recover_busy", {busy_o, gnt1_o, done1_o}, 32'h6);
        req0_i = 1'b1; wr_nrd0_i = 1'b0; addr0_i = 11'h010;
        eng_data = 8'h5A; eng_lat = 1;
        wait_done(1, 20, n);
        check_eq("wr_done_lat", n, 3);
        check_eq("wr_done_gnt", {gnt0_o, gnt1_o, done1_o, done0_o}, 32'h6);
        check_eq("wr_held", {eng_addr_o, eng_wdata_o}, {11'h7FF, 8'h3C});
        req1_i = 1'b0;
        tick();
        check_eq("wr_idle_gap", {gnt0_o, busy_o}, 32'h0);
        tick();
        check_eq("pend_issue", {gnt0_o, eng_rd_o}, 32'h3);
        check_eq("pend_addr", eng_addr_o, 32'h010);
        wait_done(0, 20, n);
        check_eq("pend_lat", n, 2);
        check_eq("pend_rdata", rdata_o, 32'h5A);
        req0_i = 1'b0;
        tick();

        // Req drop during WAIT_ACK
        eng_lat = 4; eng_data = 8'h33;
        base = n_strobe;
        req0_i = 1'b1; addr0_i = 11'h0AA;
        tick();
        check_eq("drop_issue", {gnt0_o, eng_rd_o}, 32'h3);
        tick();
        req0_i = 1'b0;
        wait_done(0, 20, n);
        check_eq("drop_done0", done0_o, 1);
        check_eq("drop_rdata", rdata_o, 32'h33);
        repeat (3) tick();
        check_eq("drop_strobes", n_strobe - base, 1);
        check_eq("drop_idle", {busy_o, gnt0_o}, 32'h0);

        // Reset during RECOVER
        eng_lat = 1;
        req1_i = 1'b1; wr_nrd1_i = 1'b1; addr1_i = 11'h2C3; wdata1_i = 8'h99;
        tick();
        check_eq("rst_issue", eng_wr_o, 1);
        repeat (2) tick();
        check_eq("rst_pre_busy", {busy_o, gnt1_o}, 32'h3);
        rst_ni = 1'b0;
        req0_i = 1'b1; wr_nrd0_i = 1'b0; wr_nrd1_i = 1'b0;
        tick();
        check_all_zero("rst_mid");
        rst_ni = 1'b1;

        // Fairness: both held high, grants alternate starting at port 0
        eng_data = 8'h11;
        for (int i = 0; i < 4; i++) begin
            wait_any(1'b1, 10, n);
            check_eq($sformatf("fair_gnt%0d", i), {gnt0_o, gnt1_o}, (i % 2 == 0) ? 32'h2 : 32'h1);
            wait_any(1'b0, 20, n);
            check_eq($sformatf("fair_done%0d", i), {done0_o, done1_o}, (i % 2 == 0) ? 32'h2 : 32'h1);
        end
        req0_i = 1'b0; req1_i = 1'b0;
        repeat (2) tick();
        check_eq("fair_idle", busy_o, 0);

        // Engine never acks
        eng_auto = 1'b0;
        req0_i = 1'b1; addr0_i = 11'h001;
        tick();
        check_eq("to_issue", {gnt0_o, eng_rd_o}, 32'h3);
`ifdef EEPROM_ARB_TIMEOUT_EN
        wait_done(0, 30, n);
        check_eq("to_lat", n, 9);
        check_eq("to_done_err", {done0_o, err_o}, 32'h3);
        check_eq("to_rdata", rdata_o, 32'h00);
        req0_i = 1'b0;
        tick();
        check_eq("to_after", {err_o, busy_o}, 32'h0);
`else
        wait_done(0, 40, n);
        check_eq("to_no_done", done0_o, 0);
        check_eq("to_busy", {busy_o, err_o}, 32'h2);
        req0_i = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eeprom_arb.md
# eeprom_arb

Two-port round-robin arbiter and transaction sequencer that shares one serial EEPROM byte read/write engine between two requesters. It sits between the requesters and the engine, issues single-cycle WR/RD strobes, and holds address and write data stable for the whole transaction. After every write it enforces an EEPROM internal write-recovery gap. It returns read data and a completion pulse to the winning port.

## Interface
- TWR_CYCLES, 1000: idle cycles after a write ACK before the next transaction; 0 = no gap; 16-bit range
- TIMEOUT_CYCLES, 4096: WAIT_ACK cycle limit; only used with EEPROM_ARB_TIMEOUT_EN; 16-bit range
- CLK  in  1  system clock; all logic on posedge
- RESET  in  1  synchronous, active-low reset
- req0, req1  in  1 each  transaction request; held high until matching done
- wr_nrd0, wr_nrd1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  11 each  EEPROM byte address
- wdata0, wdata1  in  8 each  write byte
- gnt0, gnt1  out  1 each  port owns engine, ISSUE through DONE inclusive
- done0, done1  out  1 each  one-cycle completion pulse
- rdata  out  8  read byte; valid while done0/done1 is high
- err  out  1  high with done when transaction timed out
- busy  out  1  state != IDLE
- eng_wr, eng_rd  out  1 each  one-cycle engine strobes
- eng_addr  out  11  engine address, held stable ISSUE..DONE
- eng_wdata  out  8  engine write data, held stable ISSUE..DONE
- eng_rdata  in  8  engine parallel read data
- eng_ack  in  1  engine one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, WAIT_ACK, RECOVER, DONE.
- IDLE: if any req is high, pick the winner, latch its wr_nrd/addr/wdata into eng_* and the owner register, then go to ISSUE.
- Round-robin: a `last` pointer holds the most recently served port; reset value = 1, so port 0 wins the first tie. If both req are high, the port != last wins. If one req is high, it wins. `last` updates on DONE entry.
- ISSUE: eng_wr = wr_nrd or eng_rd = ~wr_nrd for exactly this cycle; gnt of the owner rises; go to WAIT_ACK.
- WAIT_ACK: wait for eng_ack.
  - Read: capture eng_rdata into rdata on the eng_ack cycle, then go to DONE.
  - Write: go to RECOVER, loading a 16-bit counter with TWR_CYCLES. If TWR_CYCLES = 0, go straight to DONE.
- RECOVER: decrement each cycle; go to DONE when the counter reaches 1.
- DONE: owner's done high for one cycle, gnt drops on exit, return to IDLE. A new grant is possible on the cycle after DONE.
- eng_ack outside WAIT_ACK is ignored.
- A req that drops mid-transaction has no effect: the transaction completes and done still pulses.
- Reset (RESET = 0 at posedge): state IDLE, last = 1, counters 0. All outputs 0: gnt*, done*, rdata, err, busy, eng_wr, eng_rd, eng_addr, eng_wdata. An in-flight transaction is abandoned. The top level resets the engine from the same signal.

## Timing
- Req sampled high in IDLE at edge k: ISSUE during cycle k+1, with gnt, eng_* and the strobe all valid.
- Read: eng_ack sampled at edge m gives done and rdata in cycle m+1.
- Write: eng_ack at edge m gives done in cycle m+1+TWR_CYCLES.
- Minimum request-to-done latency, read: 3 cycles plus engine latency.
- Strobes are exactly one cycle wide. eng_addr and eng_wdata do not change between ISSUE and DONE.

## Configuration
- EEPROM_ARB_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT_ACK.
  - After TIMEOUT_CYCLES cycles with no eng_ack: go to DONE with err = 1 and rdata = 8'h00, skipping RECOVER.
  - `last` still advances.
- Not defined: WAIT_ACK waits indefinitely; err is constant 0; no timeout counter is built.

## Test plan
- Single read, TWR_CYCLES = 4: req0 = 1, wr_nrd0 = 0, addr0 = 11'h155; bench acks with eng_rdata = 8'hA5 five cycles after eng_rd. Expect one eng_rd pulse, eng_addr = 11'h155, then done0 with rdata = 8'hA5; done1 stays 0.
- Write recovery, TWR_CYCLES = 4: req1 write addr 11'h7FF, data 8'h3C. Expect eng_wr, eng_wdata = 8'h3C, and done1 exactly 5 cycles after eng_ack. A req0 raised during RECOVER is not granted until after done1.
- Fairness: hold req0 and req1 high continuously. Grants alternate 0,1,0,1 starting with port 0 after reset.
- Req drop: deassert req0 in WAIT_ACK. The transaction completes, done0 pulses, and no second strobe is issued.
- Reset mid-op: pull RESET low during RECOVER. On the next cycle all outputs are 0 and state is IDLE; the next tie grants port 0.
- Timeout, with EEPROM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8: never ack. done pulses with err = 1 and rdata = 8'h00 after 8 WAIT_ACK cycles. Without the macro, busy stays 1.
